// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, reads four ROM bytes per cycle and
// presents a little-endian 32-bit instruction to decode over valid/ready.
// Redirects take priority; misaligned or out-of-range PCs park the stage in FAULT.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              if_ready,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic              fetch_fault,
  output logic              rom_re,
  output logic [ADDR_W-1:0] rom_addr0,
  output logic [ADDR_W-1:0] rom_addr1,
  output logic [ADDR_W-1:0] rom_addr2,
  output logic [ADDR_W-1:0] rom_addr3,
  input  logic [7:0]        rom_data0,
  input  logic [7:0]        rom_data1,
  input  logic [7:0]        rom_data2,
  input  logic [7:0]        rom_data3
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       if_pc_q, if_pc_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d;
  logic              fetch_fault_q, fetch_fault_d;
  logic              adv;
  logic              fetch_bad;
  logic              fetch_en;
  logic [ADDR_W-1:0] rom_addr [4];

  // A PC is unusable if it is not word aligned or lies beyond the ROM.
  function automatic logic is_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc[31:ADDR_W] != '0);
  endfunction

  // Byte addresses PC+0..PC+3; driven regardless of rom_re.
  for (genvar gi = 0; gi < 4; gi++) begin : g_addr
    assign rom_addr[gi] = fetch_pc_q[ADDR_W-1:0] + ADDR_W'(gi);
  end

  assign rom_addr0 = rom_addr[0];
  assign rom_addr1 = rom_addr[1];
  assign rom_addr2 = rom_addr[2];
  assign rom_addr3 = rom_addr[3];

  // Output register is free when empty or being consumed this cycle.
  assign adv       = !if_valid_q || if_ready;
  assign fetch_bad = is_bad(fetch_pc_q);
  assign fetch_en  = (state_q == ST_RUN) && adv && !fetch_bad && !redirect_valid;
  assign rom_re    = fetch_en;

  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;
  assign fetch_fault = fetch_fault_q;

  // Next-state logic: redirect first, then per-state fetch/drain behaviour.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    if_pc_d       = if_pc_q;
    if_inst_d     = if_inst_q;
    if_valid_d    = if_valid_q && !if_ready;
    fetch_fault_d = fetch_fault_q;

    if (redirect_valid) begin
      // The held word is flushed even if decode is ready this cycle.
      if_valid_d = 1'b0;
      fetch_pc_d = redirect_pc;
      if (is_bad(redirect_pc)) begin
        state_d       = ST_FAULT;
        fetch_fault_d = 1'b1;
      end else begin
        state_d       = ST_RUN;
        fetch_fault_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (fetch_bad) begin
            state_d       = ST_FAULT;
            fetch_fault_d = 1'b1;
          end else if (adv) begin
            if_inst_d  = {rom_data3, rom_data2, rom_data1, rom_data0};
            if_pc_d    = fetch_pc_q;
            if_valid_d = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      if_pc_q       <= 32'd0;
      if_inst_q     <= 32'd0;
      if_valid_q    <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      if_pc_q       <= if_pc_d;
      if_inst_q     <= if_inst_d;
      if_valid_q    <= if_valid_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a ROM model feeds the DUT, and each
// scenario pushes the instructions decode should see into a scoreboard queue.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        fetch_fault;
  logic        rom_re;
  logic [10:0] rom_addr0, rom_addr1, rom_addr2, rom_addr3;
  logic [7:0]  rom_data0, rom_data1, rom_data2, rom_data3;

  logic [7:0]  rom [2048];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;
  int   vectors = 0;
  int   miscompares = 0;

  inst_fetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_ready(if_ready), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .fetch_fault(fetch_fault), .rom_re(rom_re),
    .rom_addr0(rom_addr0), .rom_addr1(rom_addr1), .rom_addr2(rom_addr2), .rom_addr3(rom_addr3),
    .rom_data0(rom_data0), .rom_data1(rom_data1), .rom_data2(rom_data2), .rom_data3(rom_data3)
  );

  always #5 clk = ~clk;

  assign rom_data0 = rom[rom_addr0];
  assign rom_data1 = rom[rom_addr1];
  assign rom_data2 = rom[rom_addr2];
  assign rom_data3 = rom[rom_addr3];

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [10:0] a;
    a = pc[10:0];
    return {rom[a + 11'd3], rom[a + 11'd2], rom[a + 11'd1], rom[a]};
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, exp_word(pc)});
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, required 0", if_valid); end
    vectors++; if (if_pc !== 32'd0) begin miscompares++; $display("FAIL reset_pc: got %h, required 0", if_pc); end
    vectors++; if (if_inst !== 32'd0) begin miscompares++; $display("FAIL reset_inst: got %h, required 0", if_inst); end
    vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b, required 0", fetch_fault); end
    vectors++; if (rom_re !== 1'b0) begin miscompares++; $display("FAIL reset_rom_re: got %b, required 0", rom_re); end
    vectors++; if (rom_addr3 !== 11'd3) begin miscompares++; $display("FAIL reset_addr3: got %h, required 003", rom_addr3); end
    $display("reset: if_valid=%b if_pc=%h rom_addr0=%h", if_valid, if_pc, rom_addr0);
  endtask

  task automatic test_stream();
    exp_q.delete();
    for (int k = 0; k < 8; k++) push_exp(32'(k * 4));
    @(negedge clk);
    rst = 1'b0; if_ready = 1'b1;
    #1;
    vectors++; if (rom_re !== 1'b0) begin miscompares++; $display("FAIL idle_rom_re: got %b, required 0", rom_re); end
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %b, required 0", if_valid); end
        vectors++; if (rom_re !== 1'b1) begin miscompares++; $display("FAIL first_rom_re: got %b, required 1", rom_re); end
      end
      if (c == 2) begin
        vectors++; if (if_pc !== 32'h0 || if_inst !== 32'h0000_0013) begin miscompares++; $display("FAIL first_word: got pc=%h inst=%h, required pc=0 inst=00000013", if_pc, if_inst); end
      end
      if (c == 3) begin
        vectors++; if (if_pc !== 32'h4 || if_inst !== 32'h0010_0093) begin miscompares++; $display("FAIL second_word: got pc=%h inst=%h, required pc=4 inst=00100093", if_pc, if_inst); end
      end
      if (if_valid && if_ready && !redirect_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL stream_extra: got pc=%h, required none", if_pc); end
        else begin
          exp_e = exp_q.pop_front();
          if (if_pc !== exp_e.pc || if_inst !== exp_e.inst) begin miscompares++; $display("FAIL stream_word: got pc=%h inst=%h, required pc=%h inst=%h", if_pc, if_inst, exp_e.pc, exp_e.inst); end
          $display("stream: pc=%h inst=%h", if_pc, if_inst);
        end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL stream_missing: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_hold();
    exp_q.delete();
    for (int k = 0; k < 8; k++) push_exp(32'h40 + 32'(k * 4));
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      redirect_valid = (c == 0); redirect_pc = 32'h40; if_ready = !(c >= 4 && c <= 6);
      #1;
      if (c == 1) begin
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL hold_bubble: got %b, required 0", if_valid); end
      end
      if (if_valid && !if_ready) begin
        vectors++;
        if (exp_q.size() == 0 || if_pc !== exp_q[0].pc || if_inst !== exp_q[0].inst || rom_re !== 1'b0) begin
          miscompares++; $display("FAIL hold_stable: got pc=%h rom_re=%b, required pc=%h rom_re=0", if_pc, rom_re, (exp_q.size() != 0) ? exp_q[0].pc : 32'hx);
        end
        $display("hold: pc=%h rom_re=%b", if_pc, rom_re);
      end
      if (if_valid && if_ready && !redirect_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL hold_extra: got pc=%h, required none", if_pc); end
        else begin
          exp_e = exp_q.pop_front();
          if (if_pc !== exp_e.pc || if_inst !== exp_e.inst) begin miscompares++; $display("FAIL hold_word: got pc=%h inst=%h, required pc=%h inst=%h", if_pc, if_inst, exp_e.pc, exp_e.inst); end
          $display("hold: accept pc=%h inst=%h", if_pc, if_inst);
        end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL hold_missing: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    exp_q.delete();
    for (int k = 0; k < 3; k++) push_exp(32'h100 + 32'(k * 4));
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      redirect_valid = (c == 0); redirect_pc = 32'h100; if_ready = 1'b1;
      #1;
      if (c == 0) begin
        vectors++; if (if_valid !== 1'b1 || rom_re !== 1'b0) begin miscompares++; $display("FAIL redir_pre: got valid=%b rom_re=%b, required valid=1 rom_re=0", if_valid, rom_re); end
      end
      if (c == 1) begin
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush: got %b, required 0", if_valid); end
      end
      if (if_valid && if_ready && !redirect_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL redir_extra: got pc=%h, required none", if_pc); end
        else begin
          exp_e = exp_q.pop_front();
          if (if_pc !== exp_e.pc || if_inst !== exp_e.inst) begin miscompares++; $display("FAIL redir_word: got pc=%h inst=%h, required pc=%h inst=%h", if_pc, if_inst, exp_e.pc, exp_e.inst); end
          $display("redirect: pc=%h inst=%h", if_pc, if_inst);
        end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL redir_missing: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_fault();
    exp_q.delete();
    push_exp(32'h8); push_exp(32'hC);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      redirect_valid = (c == 0 || c == 2); redirect_pc = (c == 0) ? 32'h102 : 32'h8; if_ready = 1'b1;
      #1;
      if (c == 1) begin
        vectors++; if (fetch_fault !== 1'b1 || if_valid !== 1'b0 || rom_re !== 1'b0) begin miscompares++; $display("FAIL fault_set: got fault=%b valid=%b rom_re=%b, required 1 0 0", fetch_fault, if_valid, rom_re); end
        vectors++; if (rom_addr0 !== 11'h102) begin miscompares++; $display("FAIL fault_addr: got %h, required 102", rom_addr0); end
      end
      if (c == 2) begin
        vectors++; if (fetch_fault !== 1'b1 || rom_re !== 1'b0) begin miscompares++; $display("FAIL fault_sticky: got fault=%b rom_re=%b, required 1 0", fetch_fault, rom_re); end
      end
      if (c == 3) begin
        vectors++; if (fetch_fault !== 1'b0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL fault_clear: got fault=%b valid=%b, required 0 0", fetch_fault, if_valid); end
      end
      if (if_valid && if_ready && !redirect_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL fault_extra: got pc=%h, required none", if_pc); end
        else begin
          exp_e = exp_q.pop_front();
          if (if_pc !== exp_e.pc || if_inst !== exp_e.inst) begin miscompares++; $display("FAIL fault_word: got pc=%h inst=%h, required pc=%h inst=%h", if_pc, if_inst, exp_e.pc, exp_e.inst); end
          $display("fault: pc=%h inst=%h", if_pc, if_inst);
        end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL fault_missing: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_end_of_rom();
    exp_q.delete();
    push_exp(32'h7F8); push_exp(32'h7FC);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      redirect_valid = (c == 0); redirect_pc = 32'h7F8; if_ready = 1'b1;
      #1;
      if (c == 2) begin
        vectors++; if (rom_re !== 1'b1 || rom_addr0 !== 11'h7FC || rom_addr3 !== 11'h7FF) begin miscompares++; $display("FAIL eor_addrs: got rom_re=%b a0=%h a3=%h, required 1 7fc 7ff", rom_re, rom_addr0, rom_addr3); end
      end
      if (c == 3) begin
        vectors++; if (rom_re !== 1'b0 || fetch_fault !== 1'b0) begin miscompares++; $display("FAIL eor_stop: got rom_re=%b fault=%b, required 0 0", rom_re, fetch_fault); end
      end
      if (c >= 4) begin
        vectors++; if (fetch_fault !== 1'b1 || if_valid !== 1'b0) begin miscompares++; $display("FAIL eor_fault: got fault=%b valid=%b, required 1 0", fetch_fault, if_valid); end
      end
      if (if_valid && if_ready && !redirect_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin miscompares++; $display("FAIL eor_extra: got pc=%h, required none", if_pc); end
        else begin
          exp_e = exp_q.pop_front();
          if (if_pc !== exp_e.pc || if_inst !== exp_e.inst) begin miscompares++; $display("FAIL eor_word: got pc=%h inst=%h, required pc=%h inst=%h", if_pc, if_inst, exp_e.pc, exp_e.inst); end
          $display("end_of_rom: pc=%h inst=%h", if_pc, if_inst);
        end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL eor_missing: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h20; if_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk); #1;
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_inst !== exp_word(32'h20)) begin miscompares++; $display("FAIL rmid_pre: got valid=%b pc=%h inst=%h, required 1 20 %h", if_valid, if_pc, if_inst, exp_word(32'h20)); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_inst !== 32'd0 || rom_re !== 1'b0 || fetch_fault !== 1'b0) begin
      miscompares++; $display("FAIL rmid_async: got valid=%b pc=%h inst=%h rom_re=%b fault=%b, required all 0", if_valid, if_pc, if_inst, rom_re, fetch_fault);
    end
    vectors++; if (rom_addr0 !== 11'd0) begin miscompares++; $display("FAIL rmid_addr: got %h, required 000", rom_addr0); end
    @(negedge clk);
    rst = 1'b0; if_ready = 1'b1;
    #1;
    vectors++; if (rom_re !== 1'b0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_idle: got rom_re=%b valid=%b, required 0 0", rom_re, if_valid); end
    @(negedge clk); #1;
    vectors++; if (if_valid !== 1'b0 || rom_re !== 1'b1) begin miscompares++; $display("FAIL rmid_run: got valid=%b rom_re=%b, required 0 1", if_valid, rom_re); end
    @(negedge clk); #1;
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0000_0013) begin miscompares++; $display("FAIL rmid_first: got valid=%b pc=%h inst=%h, required 1 0 00000013", if_valid, if_pc, if_inst); end
    $display("reset_mid: pc=%h inst=%h", if_pc, if_inst);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'(i * 37 + 11);
    rom[0] = 8'h13; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h00;
    rom[4] = 8'h93; rom[5] = 8'h00; rom[6] = 8'h10; rom[7] = 8'h00;
    test_reset();
    test_stream();
    test_hold();
    test_redirect();
    test_fault();
    test_end_of_rom();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
